nn_argmax_classifier: RTL
=========================

Name: nn_argmax_classifier

Overview:
- Output stage directly downstream of the second dense layer: takes its signed 32-bit score vector and reduces it to a keyword decision.
- Sequentially scans the scores, one per cycle, to find the winning class index, the best score and the runner-up score.
- Flags a detection only if the best score clears an absolute threshold and beats the runner-up by a minimum margin.
- Result is presented on a valid/ready handshake to the display/control logic.

Parameters:
- N_CLASSES, default OUT_SIZE_2 (10), number of scores scanned.
- SCORE_THRESHOLD, default 0, signed 32-bit minimum best score for a detection.
- MIN_MARGIN, default 256, unsigned 33-bit minimum (best − second) for a detection.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  score vector valid.
- in_ready  out  1  block can accept a vector; high only in IDLE.
- score_vector  in  32 x N_CLASSES, signed  scores from the dense layer.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- class_idx  out  CLASS_IDX_W  index of the maximum score.
- max_score  out  32 signed  best score.
- margin  out  33 unsigned  best − second, computed at full 33-bit width.
- detected  out  1  max_score >= SCORE_THRESHOLD and margin >= MIN_MARGIN.

Behaviour:
- Reset (synchronous, highest priority, any state including mid-scan):
  - Returns to IDLE.
  - class_idx = 0, max_score = 0, margin = 0, detected = 0, out_valid = 0.
  - in_ready = 0 while rst is high; in_ready = 1 from the first cycle after rst deasserts.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge, latch score_vector into an internal register, which isolates the scan from later upstream changes.
  - Set idx = 0, best = −2^31, second = −2^31, best_idx = 0; go to SCAN.
- SCAN:
  - One element per cycle, s = latched[idx].
  - If s > best (strict): second = best, best = s, best_idx = idx.
  - Else if s > second: second = s.
  - Ties keep the lower index. An element equal to best updates second, so an exact tie gives margin 0.
  - idx increments; after idx = N_CLASSES−1 is processed, register the outputs and go to DONE.
  - Latency: out_valid goes high exactly N_CLASSES cycles after the accepting edge.
- DONE:
  - out_valid = 1.
  - class_idx, max_score, margin and detected are stable until the handshake completes.
  - On out_valid && out_ready, go to IDLE. out_valid drops and in_ready rises on the next cycle.
  - No combinational path from out_ready to in_ready. in_valid is ignored outside IDLE.
- Arithmetic:
  - margin = sign-extended 33-bit best − second; never negative; max 2^32 − 1.
  - Comparisons are signed 32-bit.
- N_CLASSES = 1: second stays −2^31, so margin = best + 2^31.
- Throughput: one vector per N_CLASSES + 2 cycles with out_ready held high.

Decomposition:
- Add to nn_parameters:
  - CLASS_IDX_W = $clog2(N_CLASSES), minimum 1.
  - SCORE_W = 32, MARGIN_W = 33.
  - The FSM state enum type.
- A single module; no sub-module is warranted. The compare/update step is a small combinational block inside it.

Test Plan:
- Scores {5,−3,100,7,0,1,2,3,4,60} → class_idx 2, max_score 100, margin 40; detected 0 (40 < 256); out_valid exactly 10 cycles after the accepting edge.
- Scores {1000 at index 4, 200 at index 7, all others −50} → class_idx 4, margin 800, detected 1.
- Tie, 300 at indices 3 and 8 → class_idx 3, margin 0, detected 0.
- All scores −2^31 → class_idx 0, max_score −2^31, margin 0, detected 0.
- Edge cases (SCORE_THRESHOLD = 0):
  - Scores with best −10 and margin 500 → detected 0.
  - Best 2^31−1 with all others −2^31 → margin 2^32−1, detected 1.
- Handshake and reset:
  - Hold out_ready = 0 for 20 cycles → outputs frozen and in_valid ignored; then pulse out_ready → in_ready rises the next cycle.
  - Assert rst mid-scan at idx 5 → all outputs 0, in_ready 0 while rst high and 1 the cycle after release; a new vector then scans from index 0.

Source files
------------

// File: rtl/nn_parameters.sv
// Shared widths, limits and FSM state type for the keyword-spotting network output stages.
package nn_parameters;

  localparam int OUT_SIZE_2 = 10;
  localparam int SCORE_W    = 32;
  localparam int MARGIN_W   = 33;

  // Index width for a given class count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CLASS_IDX_W = idx_w(OUT_SIZE_2);

  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

endpackage

// File: rtl/nn_argmax_classifier.sv
// Sequential argmax over the dense-layer scores with threshold/margin detection.
// One score per cycle; result held on a valid/ready handshake until consumed.
module nn_argmax_classifier
  import nn_parameters::*;
#(
  parameter int                          N_CLASSES       = OUT_SIZE_2,
  parameter logic signed [SCORE_W-1:0]   SCORE_THRESHOLD = '0,
  parameter logic        [MARGIN_W-1:0]  MIN_MARGIN      = 33'd256,
  localparam int                         IDX_W           = idx_w(N_CLASSES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_CLASSES-1:0][SCORE_W-1:0]     score_vector,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [IDX_W-1:0]                      class_idx,
  output logic signed [SCORE_W-1:0]             max_score,
  output logic [MARGIN_W-1:0]                   margin,
  output logic                                  detected
);

  argmax_state_t                     state;
  logic [N_CLASSES-1:0][SCORE_W-1:0] latched;
  logic [IDX_W-1:0]                  idx;
  logic signed [SCORE_W-1:0]         best;
  logic signed [SCORE_W-1:0]         second;
  logic [IDX_W-1:0]                  best_idx;

  logic signed [SCORE_W-1:0]         cur;
  logic signed [SCORE_W-1:0]         nxt_best;
  logic signed [SCORE_W-1:0]         nxt_second;
  logic [IDX_W-1:0]                  nxt_best_idx;
  logic [MARGIN_W-1:0]               nxt_margin;
  logic                              nxt_detected;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  // Readiness depends only on state and reset, never on out_ready.
  assign in_ready = (state == IDLE) && !rst;

  // Compare/update step. An element equal to best falls through to the
  // second-place test, so exact ties keep the lower index and give margin 0.
  always_comb begin
    cur          = $signed(latched[idx]);
    nxt_best     = best;
    nxt_second   = second;
    nxt_best_idx = best_idx;
    if (cur > best) begin
      nxt_second   = best;
      nxt_best     = cur;
      nxt_best_idx = idx;
    end else if (cur > second) begin
      nxt_second = cur;
    end
    nxt_margin   = {nxt_best[SCORE_W-1], nxt_best} - {nxt_second[SCORE_W-1], nxt_second};
    nxt_detected = (nxt_best >= SCORE_THRESHOLD) && (nxt_margin >= MIN_MARGIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      latched   <= '0;
      idx       <= '0;
      best      <= SCORE_MIN;
      second    <= SCORE_MIN;
      best_idx  <= '0;
      out_valid <= 1'b0;
      class_idx <= '0;
      max_score <= '0;
      margin    <= '0;
      detected  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            latched  <= score_vector;
            idx      <= '0;
            best     <= SCORE_MIN;
            second   <= SCORE_MIN;
            best_idx <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          best     <= nxt_best;
          second   <= nxt_second;
          best_idx <= nxt_best_idx;
          if (idx == LAST_IDX) begin
            class_idx <= nxt_best_idx;
            max_score <= nxt_best;
            margin    <= nxt_margin;
            detected  <= nxt_detected;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
